// File: rtl/zbt_sram_ctrl.sv
// rtl/zbt_sram_ctrl.sv - NoBL/ZBT pipelined SRAM initiator with optional post-reset clear sweep
module zbt_sram_ctrl #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 36,
    parameter int TAG_W      = 4,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_bw,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we_n,
    output logic [3:0]        sram_bw_n,
    output logic              sram_adv_ld_n,
    output logic              sram_ce_n,
    output logic              sram_cen_n,
    output logic              sram_oe_n,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_DRAIN, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr;
    logic [1:0]          drain_cnt;

    // Command selected for issue this cycle (clear sweep or accepted request)
    logic                iss_en;
    logic                iss_wr;
    logic [ADDR_W-1:0]   iss_addr;
    logic [3:0]          iss_bw;
    logic [DATA_W-1:0]   iss_wdata;
    logic [TAG_W-1:0]    iss_tag;

    // Write-data and read-tag pipelines that track the SRAM's internal latency
    logic [DATA_W-1:0]   wd1, wd2;
    logic                wv1, wv2;
    logic                rv1, rv2, rv3;
    logic [TAG_W-1:0]    tg1, tg2, tg3;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RESET;
        else          state_q <= state_d;
    end

    // Next-state and issue-command selection
    always_comb begin
        state_d   = state_q;
        iss_en    = 1'b0;
        iss_wr    = 1'b0;
        iss_addr  = clr_addr;
        iss_bw    = 4'h0;
        iss_wdata = '0;
        iss_tag   = '0;
        unique case (state_q)
            ST_RESET: state_d = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            ST_CLEAR: begin
                iss_en = 1'b1;
                iss_wr = 1'b1;
                iss_bw = 4'hF;
                if (clr_addr == LAST_ADDR) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (drain_cnt == 2'd2) state_d = ST_RUN;
            ST_RUN: begin
                iss_en    = req_valid & req_ready;
                iss_wr    = req_wr;
                iss_addr  = req_addr;
                iss_bw    = req_wr ? req_bw : 4'h0;
                iss_wdata = req_wdata;
                iss_tag   = req_tag;
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Sweep address and drain counters; the address wraps naturally at the top
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_addr  <= '0;
            drain_cnt <= '0;
        end else begin
            if (state_q == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
            drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Handshake and init status; RUN is only left through reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            req_ready <= (state_d == ST_RUN);
            init_done <= (state_d == ST_RUN);
        end
    end

    // SRAM address/control pins, deselected whenever nothing is issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_ce_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_bw_n     <= 4'hF;
            sram_addr     <= '0;
            sram_adv_ld_n <= 1'b0;
            sram_cen_n    <= 1'b1;
            sram_oe_n     <= 1'b1;
        end else begin
            sram_ce_n     <= ~iss_en;
            sram_we_n     <= ~(iss_en & iss_wr);
            sram_bw_n     <= (iss_en & iss_wr) ? ~iss_bw : 4'hF;
            if (iss_en) sram_addr <= iss_addr;
            sram_adv_ld_n <= 1'b0;
            sram_cen_n    <= 1'b0;
            sram_oe_n     <= 1'b0;
        end
    end

    // Write data travels two stages, then drives the pad for one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd1         <= '0;
            wd2         <= '0;
            wv1         <= 1'b0;
            wv2         <= 1'b0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
        end else begin
            wd1         <= iss_wdata;
            wv1         <= iss_en & iss_wr;
            wd2         <= wd1;
            wv2         <= wv1;
            sram_dq_out <= wd2;
            sram_dq_oe  <= wv2;
        end
    end

    // Read flag and tag shift alongside the SRAM read latency; data is captured at the end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv1      <= 1'b0;
            rv2      <= 1'b0;
            rv3      <= 1'b0;
            tg1      <= '0;
            tg2      <= '0;
            tg3      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_tag   <= '0;
        end else begin
            rv1      <= iss_en & ~iss_wr;
            tg1      <= iss_tag;
            rv2      <= rv1;
            tg2      <= tg1;
            rv3      <= rv2;
            tg3      <= tg2;
            rd_valid <= rv3;
            if (rv3) begin
                rd_data <= sram_dq_in;
                rd_tag  <= tg3;
            end
        end
    end

endmodule

// File: tb/tb_zbt_sram_ctrl.sv
// tb/tb_zbt_sram_ctrl.sv - scoreboard bench for zbt_sram_ctrl with a NoBL SRAM behavioural model
module tb_zbt_sram_ctrl;

    localparam int AW = 8;
    localparam int DW = 36;
    localparam int TW = 4;
    localparam int NWORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_bw;
    logic [TW-1:0] req_tag;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [TW-1:0] rd_tag;
    logic          init_done;
    logic [AW-1:0] sram_addr;
    logic          sram_we_n, sram_adv_ld_n, sram_ce_n, sram_cen_n, sram_oe_n;
    logic [3:0]    sram_bw_n;
    logic [DW-1:0] sram_dq_out, sram_dq_in;
    logic          sram_dq_oe;

    zbt_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .INIT_CLEAR(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_bw(req_bw), .req_tag(req_tag),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag), .init_done(init_done),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_bw_n(sram_bw_n),
        .sram_adv_ld_n(sram_adv_ld_n), .sram_ce_n(sram_ce_n), .sram_cen_n(sram_cen_n),
        .sram_oe_n(sram_oe_n), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int clr_seen = 0;
    int last_clr_cyc = 0;
    int rd_pulses = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: address sampled at an edge, read data driven one edge later,
    // write data captured two edges later (write before read at the same edge)
    logic [DW-1:0] mem [NWORDS];
    logic          p1_v, p1_w, p2_v, p2_w;
    logic [AW-1:0] p1_a, p2_a;
    logic [3:0]    p1_bn, p2_bn;

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = 36'h5A5A5A5A5;
        sram_dq_in = '0;
        p1_v = 0; p2_v = 0; p1_w = 0; p2_w = 0;
        p1_a = '0; p2_a = '0; p1_bn = 4'hF; p2_bn = 4'hF;
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            p1_v = 0;
            p2_v = 0;
        end else begin
            if (p2_v && p2_w) begin
                for (int l = 0; l < 4; l++)
                    if (!p2_bn[l]) mem[p2_a][l*9 +: 9] = sram_dq_out[l*9 +: 9];
            end
            if (p1_v && !p1_w) sram_dq_in <= mem[p1_a];
            p2_v = p1_v; p2_w = p1_w; p2_a = p1_a; p2_bn = p1_bn;
            p1_v = !sram_ce_n; p1_w = !sram_we_n; p1_a = sram_addr; p1_bn = sram_bw_n;
        end
    end

    // Monitor: read responses, clear sweep sequence, and write-pad enable timing
    logic wa = 0, wb = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            clr_seen = 0;
            wa = 0;
            wb = 0;
        end else begin
            if (rd_valid) begin
                rd_pulses++;
                if (exp_q.size() == 0) begin
                    chk("rd_spurious", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e.data);
                    chk("rd_tag", rd_tag, e.tag);
                    chk("rd_latency", cyc, e.cyc);
                end
            end
            if (!init_done && !sram_ce_n) begin
                chk("clr_we_n", sram_we_n, 0);
                chk("clr_bw_n", sram_bw_n, 0);
                chk("clr_addr", sram_addr, clr_seen[AW-1:0]);
                clr_seen++;
                last_clr_cyc = cyc;
            end
            chk("dq_oe", sram_dq_oe, wb);
            wb = wa;
            wa = !sram_ce_n && !sram_we_n;
        end
    end

    // One request per call, presented at a falling edge and accepted at the next rising edge
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] bw, input logic [TW-1:0] tag,
                          input logic [DW-1:0] exp_d, input bit push);
        exp_t e;
        chk("req_ready", req_ready, 1);
        req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d; req_bw = bw; req_tag = tag;
        if (!wr && push) begin
            e.data = exp_d; e.tag = tag; e.cyc = cyc + 4;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("init_timeout", init_done, 1);
        chk("clr_count", clr_seen, NWORDS);
        chk("init_delay", cyc - last_clr_cyc, 3);
        chk("ready_after_init", req_ready, 1);
        chk("cen_n_run", sram_cen_n, 0);
        chk("oe_n_run", sram_oe_n, 0);
    endtask

    task automatic chk_reset_state();
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_bw_n", sram_bw_n, 4'hF);
        chk("rst_addr", sram_addr, 0);
        chk("rst_adv_ld_n", sram_adv_ld_n, 0);
        chk("rst_cen_n", sram_cen_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_tag", rd_tag, 0);
        chk("rst_init_done", init_done, 0);
    endtask

    initial begin
        int pulses_before;
        int n;
        reset_n = 0;
        req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; req_bw = 4'h0; req_tag = '0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        reset_n = 1;
        wait_init();

        // Top address was cleared
        do_req(0, 8'hFF, '0, 4'h0, 4'd1, 36'h000000000, 1);
        // Full write then read back
        do_req(1, 8'h10, 36'h123456789, 4'hF, 4'd0, '0, 0);
        do_req(0, 8'h10, '0, 4'h0, 4'd5, 36'h123456789, 1);
        // Single lane 1 write over zero
        do_req(1, 8'h30, 36'hFFFFFFFFF, 4'b0010, 4'd0, '0, 0);
        do_req(0, 8'h30, '0, 4'h0, 4'd6, 36'h00003FE00, 1);
        // Back-to-back alternating write/read, including lanes 3 and 0
        do_req(1, 8'h20, 36'h111111111, 4'hF, 4'd0, '0, 0);
        do_req(0, 8'h20, '0, 4'h0, 4'd7, 36'h111111111, 1);
        do_req(1, 8'h21, 36'hABCDEF012, 4'hF, 4'd0, '0, 0);
        do_req(0, 8'h21, '0, 4'h0, 4'd8, 36'hABCDEF012, 1);
        do_req(1, 8'h22, 36'h876543210, 4'b1001, 4'd0, '0, 0);
        do_req(0, 8'h22, '0, 4'h0, 4'd3, 36'h870000010, 1);

        // Idle: after the pipeline flushes the bus must be quiet
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("idle_ce_n", sram_ce_n, 1);
            chk("idle_we_n", sram_we_n, 1);
            chk("idle_dq_oe", sram_dq_oe, 0);
            @(negedge clk);
        end

        // Reset with two reads in flight: they must never return
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
        do_req(0, 8'h10, '0, 4'h0, 4'd10, '0, 0);
        do_req(0, 8'h20, '0, 4'h0, 4'd11, '0, 0);
        pulses_before = rd_pulses;
        reset_n = 0;
        #1;
        chk_reset_state();
        repeat (3) @(negedge clk);
        reset_n = 1;
        wait_init();
        chk("rd_after_reset", rd_pulses - pulses_before, 0);

        // Re-cleared location reads back zero
        do_req(0, 8'h10, '0, 4'h0, 4'd9, 36'h000000000, 1);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queue_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zbt_sram_ctrl.md
Name: zbt_sram_ctrl

Overview:
- Synthesizable initiator for the 512K x 36 NoBL (ZBT) pipelined SRAM on the board; the memory-side counterpart of the SRAM device model.
- Accepts single-word read/write requests from internal logic and drives the SRAM address, control and byte-select pins with the required two-cycle write-data and read-data pipeline.
- Returns read data with a fixed latency and an echoed tag.
- After reset, optionally sweeps the whole array to zero before accepting requests.

Parameters:
- ADDR_W, 19, SRAM word address width
- DATA_W, 36, SRAM data width (4 byte lanes of 9 bits)
- TAG_W, 4, width of request tag echoed on read response
- INIT_CLEAR, 1, 1 = zero every location after reset before asserting init_done

Ports:
- clk  in  1  system clock; SRAM clocked from same clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_bw  in  4  byte-lane enables, active high, bit3 = [35:27]
- req_tag  in  TAG_W  tag returned with read data
- rd_valid  out  1  read data valid, one-cycle pulse, no backpressure
- rd_data  out  DATA_W  read data
- rd_tag  out  TAG_W  tag of returned read
- init_done  out  1  high once the clear sweep is complete (or immediately if INIT_CLEAR=0)
- sram_addr  out  ADDR_W  SRAM address
- sram_we_n  out  1  SRAM write enable, low = write
- sram_bw_n  out  4  SRAM byte write selects, low = write lane
- sram_adv_ld_n  out  1  constant 0 (load only, no bursts)
- sram_ce_n  out  1  chip enable, low = selected; ce2/ce3b tied at top level
- sram_cen_n  out  1  clock enable, constant 0 after reset
- sram_oe_n  out  1  output enable, constant 0 after reset
- sram_dq_out  out  DATA_W  write data to pad
- sram_dq_oe  out  1  pad output enable (top level instantiates tristate)
- sram_dq_in  in  DATA_W  data from pad

Behaviour:
- All SRAM pin outputs are driven from flops.
- Reset values:
  - sram_ce_n=1, sram_we_n=1, sram_bw_n=4'hF, sram_addr=0, sram_adv_ld_n=0.
  - sram_cen_n=1 and sram_oe_n=1 while in reset, 0 from the first clock after reset.
  - sram_dq_oe=0, sram_dq_out=0, req_ready=0, rd_valid=0, rd_data=0, rd_tag=0, init_done=0.
- FSM states: RESET -> CLEAR (if INIT_CLEAR) or RUN. CLEAR -> DRAIN. DRAIN -> RUN.
- CLEAR:
  - Issue one write per cycle, addr 0..2^ADDR_W-1, data 0, bw_n=0.
  - After the last address is issued, go to DRAIN.
- DRAIN: wait 3 cycles for the write pipeline to empty, then set init_done=1 and go to RUN.
- RUN: req_ready=1 every cycle (full throughput, back-to-back read/write in any mix, no turnaround bubbles).
- Accept edge T0 (req_valid & req_ready):
  - Pins updated after T0: ce_n=0, addr, we_n=~req_wr; bw_n=~req_bw for writes, 4'hF for reads.
  - The SRAM samples at T0+1.
  - No accept at an edge: ce_n=1, we_n=1, bw_n=F (deselect).
- Write data: req_wdata is delayed through 2 registers. sram_dq_out and sram_dq_oe=1 are set after edge T0+2 and held for exactly one cycle, so the SRAM captures the data at edge T0+3.
- Read data:
  - sram_dq_in is captured at edge T0+3 into an input register.
  - rd_valid=1 with rd_data and rd_tag after edge T0+3.
  - Fixed latency: 3 cycles from acceptance to rd_valid high (consumer samples at T0+4).
- Tag and read flag are carried in a 3-stage shift pipeline alongside the data.
- Write-then-read to the same address on consecutive accepts returns the new data (the SRAM handles ordering; the controller adds no hazard logic).
- Reset asserted mid-operation: all pipelines are cleared and in-flight reads are dropped (no rd_valid). The FSM restarts, including a new clear sweep if INIT_CLEAR.
- Address counter in CLEAR wraps exactly at 2^ADDR_W-1; no extra write is issued.

Test Plan:
- Reset release with INIT_CLEAR=1 -> exactly 524288 writes of 0 issued, init_done rises 3 cycles after the last write, req_ready=1 thereafter; a read of addr 0x7FFFF returns 0.
- Write addr 0x00010 data 0x123456789 bw=F, then read 0x00010 tag 5 -> rd_valid exactly 3 cycles after the read accept, rd_data=0x123456789, rd_tag=5.
- Partial write bw=4'b0010 data 0xFFFFFFFFF to a location holding 0 -> read returns 0x00003FE00.
- Alternating W/R/W/R every cycle on 4 addresses -> 2 rd_valid pulses with correct data; sram_dq_oe is high only in the cycle after T0+2 of each write; no idle cycles.
- Idle cycles between requests -> sram_ce_n=1, sram_we_n=1, sram_dq_oe=0 in each idle cycle.
- reset_n pulled low with 2 reads in flight -> no rd_valid after reset; init_done=0 and the clear sweep restarts from address 0.
